// File: rtl/sfm_pkg.sv
// Shared constants and control types for the softmax streamer/strobe blocks.
package sfm_pkg;

  localparam int unsigned SFM_EW          = 16;
  localparam logic [15:0] SFM_PAD_NEG_INF = 16'hFF80;
  localparam int unsigned SFM_SIDEBAND_W  = 32;

  typedef struct packed {
    logic [31:0] tot_len;
    logic [31:0] d0_len;
  } addressgen_ctrl_t;

  typedef struct packed {
    addressgen_ctrl_t addressgen_ctrl;
  } hci_streamer_ctrl_t;

endpackage

// File: rtl/sfm_tail_pad_mask.sv
// Combinational element-slot pad: any slot not fully covered by the first
// lftovr bytes is replaced by PAD_ELEM when pad_en is set.
module sfm_tail_pad_mask
  import sfm_pkg::*;
#(
  parameter int unsigned   ACTUAL_DW = 128,
  parameter int unsigned   EW        = SFM_EW,
  parameter logic [EW-1:0] PAD_ELEM  = SFM_PAD_NEG_INF,
  localparam int unsigned  LW        = $clog2(ACTUAL_DW/8)
) (
  input  logic [LW-1:0]        lftovr,
  input  logic                 pad_en,
  input  logic [ACTUAL_DW-1:0] data,
  output logic [ACTUAL_DW-1:0] padded
);

  localparam int unsigned NE = ACTUAL_DW / EW;
  localparam int unsigned EB = EW / 8;

  always_comb begin
    padded = data;
    for (int unsigned e = 0; e < NE; e++) begin
      // a slot survives only if its last byte lies below lftovr
      if (pad_en && (((e + 1) * EB) > 32'(lftovr))) begin
        padded[e*EW +: EW] = PAD_ELEM;
      end
    end
  end

endmodule

// File: rtl/sfm_streamer_tail_pad.sv
// Registered load-side slice that counts beats per vector and pads the
// unloaded tail elements of the final beat.
module sfm_streamer_tail_pad
  import sfm_pkg::*;
#(
  parameter int unsigned   DW       = 160,
  parameter int unsigned   EW       = SFM_EW,
  parameter logic [EW-1:0] PAD_ELEM = SFM_PAD_NEG_INF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  hci_streamer_ctrl_t stream_ctrl_i,
  input  logic [DW-1:0]      stream_i_data,
  input  logic [DW/8-1:0]    stream_i_strb,
  input  logic               stream_i_valid,
  output logic               stream_i_ready,
  output logic [DW-1:0]      stream_o_data,
  output logic [DW/8-1:0]    stream_o_strb,
  output logic               stream_o_valid,
  input  logic               stream_o_ready,
  output logic               last_o,
  output logic [31:0]        beat_cnt_o
);

  localparam int unsigned ACTUAL_DW = DW - SFM_SIDEBAND_W;
  localparam int unsigned LW        = $clog2(ACTUAL_DW/8);

  logic                 valid_q;
  logic                 last_q;
  logic [DW-1:0]        data_q;
  logic [DW/8-1:0]      strb_q;
  logic [31:0]          cnt_q;

  logic                 hs_in;
  logic                 is_last;
  logic                 pad_en;
  logic [31:0]          tot_len;
  logic [LW-1:0]        lftovr;
  logic [ACTUAL_DW-1:0] padded;
  logic                 unused_ctrl;

  assign tot_len     = stream_ctrl_i.addressgen_ctrl.tot_len;
  assign lftovr      = stream_ctrl_i.addressgen_ctrl.d0_len[LW-1:0];
  assign unused_ctrl = ^stream_ctrl_i.addressgen_ctrl.d0_len[31:LW];

  assign stream_i_ready = ~valid_q | stream_o_ready;
  assign hs_in          = stream_i_valid & stream_i_ready;
  // tot_len of zero never produces a last beat
  assign is_last        = (tot_len != 32'd0) && (cnt_q == tot_len - 32'd1);
  assign pad_en         = is_last & (lftovr != '0);

  sfm_tail_pad_mask #(
    .ACTUAL_DW (ACTUAL_DW),
    .EW        (EW),
    .PAD_ELEM  (PAD_ELEM)
  ) u_mask (
    .lftovr (lftovr),
    .pad_en (pad_en),
    .data   (stream_i_data[ACTUAL_DW-1:0]),
    .padded (padded)
  );

  // Output slice stage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      strb_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (hs_in) begin
      valid_q <= 1'b1;
      data_q  <= {stream_i_data[DW-1:ACTUAL_DW], padded};
      strb_q  <= stream_i_strb;
      last_q  <= is_last;
      cnt_q   <= (is_last || (tot_len == 32'd0)) ? 32'd0 : cnt_q + 32'd1;
    end else if (stream_o_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign stream_o_valid = valid_q;
  assign stream_o_data  = data_q;
  assign stream_o_strb  = strb_q;
  assign last_o         = last_q;
  assign beat_cnt_o     = cnt_q;

endmodule
